// File: rtl/stress_router.sv
// Stress-aware router: fails traffic over from node0 to node1 under stress or fault, with drain stalls and a free-running decay strobe.
// Optional macro STRESS_ROUTER_STATS_EN adds a saturating failover_cnt output.
module stress_router #(
  parameter int unsigned HI_THRESH = 200,
  parameter int unsigned LO_THRESH = 100,
  parameter int unsigned DRAIN_CYC = 2,
  parameter int unsigned DECAY_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data_a,
  input  logic [7:0] in_data_b,
  input  logic       fault_inject,
  input  logic [7:0] n0_stress,
  output logic       n0_valid,
  output logic       n1_valid,
  output logic [7:0] node_data_a,
  output logic [7:0] node_data_b,
  output logic [1:0] mac_clr,
  output logic       decay_pulse,
  output logic       route_sel
`ifdef STRESS_ROUTER_STATS_EN
  ,
  output logic [15:0] failover_cnt
`endif
);

  localparam logic [7:0]  HI_T       = HI_THRESH[7:0];
  localparam logic [7:0]  LO_T       = LO_THRESH[7:0];
  localparam logic [3:0]  DRAIN_LAST = 4'(DRAIN_CYC - 1);
  localparam logic [15:0] DECAY_LAST = 16'(DECAY_DIV - 1);

  typedef enum logic [1:0] {PRIM, DRAIN_S, SPARE, DRAIN_P} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  drain_cnt_reg;
  logic [15:0] decay_cnt_reg;
  logic        failover_go;
  logic        stress_hi, stress_lo, accept;

  assign stress_hi = (n0_stress > HI_T);
  assign stress_lo = (n0_stress < LO_T);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_next  = state_reg;
    in_ready    = 1'b0;
    route_sel   = 1'b0;
    mac_clr     = 2'b00;
    failover_go = 1'b0;
    case (state_reg)
      PRIM: begin
        in_ready = 1'b1;
        if (stress_hi || fault_inject) begin
          state_next  = DRAIN_S;
          failover_go = 1'b1;
        end
      end
      DRAIN_S: begin
        route_sel = 1'b1;
        if (drain_cnt_reg == 4'd0) mac_clr = 2'b10;
        if (drain_cnt_reg == DRAIN_LAST) state_next = SPARE;
      end
      SPARE: begin
        in_ready  = 1'b1;
        route_sel = 1'b1;
        if (stress_lo && !fault_inject) state_next = DRAIN_P;
      end
      DRAIN_P: begin
        // An abort returns to node1 before node0's accumulator is cleared.
        if (fault_inject || stress_hi) begin
          state_next = SPARE;
        end else begin
          if (drain_cnt_reg == 4'd0) mac_clr = 2'b01;
          if (drain_cnt_reg == DRAIN_LAST) state_next = PRIM;
        end
      end
      default: state_next = PRIM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= PRIM;
      drain_cnt_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      if ((state_next == state_reg) && (state_reg == DRAIN_S || state_reg == DRAIN_P))
        drain_cnt_reg <= drain_cnt_reg + 4'd1;
      else
        drain_cnt_reg <= 4'd0;
    end
  end

  // Route is captured in the accept cycle; idle cycles drive zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n0_valid    <= 1'b0;
      n1_valid    <= 1'b0;
      node_data_a <= 8'd0;
      node_data_b <= 8'd0;
    end else begin
      n0_valid    <= accept && !route_sel;
      n1_valid    <= accept && route_sel;
      node_data_a <= accept ? in_data_a : 8'd0;
      node_data_b <= accept ? in_data_b : 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decay_cnt_reg <= 16'd0;
      decay_pulse   <= 1'b0;
    end else begin
      decay_cnt_reg <= (decay_cnt_reg == DECAY_LAST) ? 16'd0 : decay_cnt_reg + 16'd1;
      decay_pulse   <= (decay_cnt_reg == DECAY_LAST);
    end
  end

`ifdef STRESS_ROUTER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      failover_cnt <= 16'd0;
    else if (failover_go && failover_cnt != 16'hFFFF)
      failover_cnt <= failover_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_stress_router.sv
// Bench for stress_router: directed and random steps checked against a cycle-level routing model.
module tb_stress_router;
  localparam int HI = 200, LO = 100, DC = 2, DD = 16;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, fault_inject = 1'b0;
  logic [7:0] in_data_a = 8'd0, in_data_b = 8'd0, n0_stress = 8'd0;
  logic       in_ready, n0_valid, n1_valid, decay_pulse, route_sel;
  logic [7:0] node_data_a, node_data_b;
  logic [1:0] mac_clr;
`ifdef STRESS_ROUTER_STATS_EN
  logic [15:0] failover_cnt;
`endif

  stress_router dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data_a(in_data_a), .in_data_b(in_data_b), .fault_inject(fault_inject),
    .n0_stress(n0_stress), .n0_valid(n0_valid), .n1_valid(n1_valid),
    .node_data_a(node_data_a), .node_data_b(node_data_b), .mac_clr(mac_clr),
    .decay_pulse(decay_pulse), .route_sel(route_sel)
`ifdef STRESS_ROUTER_STATS_EN
    , .failover_cnt(failover_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Model: target node, remaining stall cycles of a pending switch, cycles since reset.
  int         m_target, m_stall, m_tick, m_cnt;
  logic       e_n0v, e_n1v;
  logic [7:0] e_a, e_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_target = 0; m_stall = 0; m_tick = 0; m_cnt = 0;
    e_n0v = 1'b0; e_n1v = 1'b0; e_a = 8'd0; e_b = 8'd0;
  endtask

  // Called at a negedge; drives, checks, advances the model, returns at the next negedge.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic f, input logic [7:0] s);
    logic       abort, acc;
    logic [1:0] e_mac;
    in_valid = v; in_data_a = a; in_data_b = b; fault_inject = f; n0_stress = s;
    #1;
    abort = f || (int'(s) > HI);
    e_mac = 2'b00;
    if (m_stall == DC) e_mac = (m_target == 1) ? 2'b10 : (abort ? 2'b00 : 2'b01);
    chk("in_ready", in_ready, m_stall == 0);
    chk("route_sel", route_sel, m_target == 1);
    chk("mac_clr", mac_clr, e_mac);
    chk("n0_valid", n0_valid, e_n0v);
    chk("n1_valid", n1_valid, e_n1v);
    chk("node_data_a", node_data_a, e_a);
    chk("node_data_b", node_data_b, e_b);
    chk("decay_pulse", decay_pulse, (m_tick > 0) && (m_tick % DD == 0));
`ifdef STRESS_ROUTER_STATS_EN
    chk("failover_cnt", failover_cnt, m_cnt);
`endif
    @(posedge clk);
    acc   = v && (m_stall == 0);
    e_n0v = acc && (m_target == 0);
    e_n1v = acc && (m_target == 1);
    e_a   = acc ? a : 8'd0;
    e_b   = acc ? b : 8'd0;
    m_tick++;
    if (m_stall == 0) begin
      if (m_target == 0 && abort) begin
        m_target = 1; m_stall = DC;
        if (m_cnt < 65535) m_cnt++;
      end else if (m_target == 1 && int'(s) < LO && !f) begin
        m_target = 0; m_stall = DC;
      end
    end else if (m_target == 0 && abort) begin
      m_target = 1; m_stall = 0;
    end else begin
      m_stall--;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_route_sel"}, route_sel, 1'b0);
    chk({tag, "_n0_valid"}, n0_valid, 1'b0);
    chk({tag, "_n1_valid"}, n1_valid, 1'b0);
    chk({tag, "_data_a"}, node_data_a, 8'd0);
    chk({tag, "_data_b"}, node_data_b, 8'd0);
    chk({tag, "_mac_clr"}, mac_clr, 2'b00);
    chk({tag, "_decay"}, decay_pulse, 1'b0);
  endtask

  initial begin
    logic [7:0] s;
    model_reset();
    #3;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Node0 streaming, then stress at and above the threshold.
    repeat (6) step(1'b1, 8'd5, 8'd3, 1'b0, 8'd50);
    repeat (3) step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 8'd200);
    step(1'b1, 8'd7, 8'd9, 1'b0, 8'd201);
    step(1'b1, 8'd1, 8'd2, 1'b1, 8'd50);
    step(1'b1, 8'd1, 8'd2, 1'b0, 8'd10);
    repeat (3) step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 8'd150);
    chk("spare_hold", route_sel, 1'b1);
    repeat (3) step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 8'd99);
    chk("back_prim", route_sel, 1'b0);

    // Abort on the first node0 drain cycle.
    step(1'b0, 8'd0, 8'd0, 1'b0, 8'd255);
    repeat (2) step(1'b1, 8'd4, 8'd4, 1'b0, 8'd120);
    step(1'b1, 8'd8, 8'd8, 1'b0, 8'd99);
    step(1'b1, 8'd8, 8'd8, 1'b1, 8'd99);
    chk("abort_route", route_sel, 1'b1);
    chk("abort_ready", in_ready, 1'b1);
    step(1'b1, 8'd6, 8'd6, 1'b0, 8'd150);

    // Random traffic around the thresholds.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 6))
        0: s = 8'd50;  1: s = 8'd99;  2: s = 8'd100; 3: s = 8'd150;
        4: s = 8'd200; 5: s = 8'd201; default: s = 8'($urandom);
      endcase
      step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           $urandom_range(0, 15) == 0, s);
    end

    // Reset in the middle of a node1 drain with a strobe pending.
    for (int i = 0; i < 10 && !(m_target == 0 && m_stall == 0); i++)
      step(1'b0, 8'd0, 8'd0, 1'b0, 8'd50);
    chk("pre_reset_prim", route_sel, 1'b0);
    step(1'b1, 8'hA5, 8'h5A, 1'b1, 8'd50);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (36) step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 8'd50);

    // Three fault-driven failover round trips.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'd1, 8'd1, 1'b1, 8'd50);
      repeat (2) step(1'b1, 8'd2, 8'd2, 1'b0, 8'd50);
      repeat (3) step(1'b1, 8'd3, 8'd3, 1'b0, 8'd50);
    end
`ifdef STRESS_ROUTER_STATS_EN
    chk("failover_three", failover_cnt, 16'd3);
`endif
    chk("final_route", route_sel, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stress_router.md
STRESS_ROUTER -- requirements
Module: stress_router

Interface
REQ-001 SHALL have parameter HI_THRESH, default 200, node0 stress level that triggers failover to node1.
REQ-002 SHALL have parameter LO_THRESH, default 100, node0 stress level below which traffic returns to node0; LO_THRESH < HI_THRESH.
REQ-003 SHALL have parameter DRAIN_CYC, default 2, number of stall cycles per route switch (1..15).
REQ-004 SHALL have parameter DECAY_DIV, default 16, period in cycles of decay_pulse (2..65535).
REQ-005 SHALL have ports, in this order:
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  in_valid  in  1  spike transaction offered.
  in_ready  out  1  transaction accepted when in_valid && in_ready.
  in_data_a  in  8  operand A.
  in_data_b  in  8  operand B.
  fault_inject  in  1  forces failover while high.
  n0_stress  in  8  stress register of node0.
  n0_valid  out  1  spike/mac_en strobe to node0.
  n1_valid  out  1  spike/mac_en strobe to node1.
  node_data_a  out  8  operand A to the selected node; 0 when neither strobe is high.
  node_data_b  out  8  operand B to the selected node; 0 when neither strobe is high.
  mac_clr  out  2  per-node accumulator clear pulse, bit0 node0, bit1 node1.
  decay_pulse  out  1  periodic decay strobe to both nodes.
  route_sel  out  1  0 = node0 active, 1 = node1 active.

Function
REQ-006 SHALL implement FSM states PRIM, DRAIN_S, SPARE, DRAIN_P.
REQ-007 In PRIM, if n0_stress > HI_THRESH or fault_inject, the FSM SHALL go to DRAIN_S next cycle.
REQ-008 In SPARE, if n0_stress < LO_THRESH and !fault_inject, the FSM SHALL go to DRAIN_P next cycle; stress in [LO_THRESH, HI_THRESH] SHALL cause no transition (hysteresis).
REQ-009 In DRAIN_S and DRAIN_P the FSM SHALL hold for exactly DRAIN_CYC cycles, then enter SPARE and PRIM respectively.
REQ-010 In DRAIN_P, if fault_inject or n0_stress > HI_THRESH, the FSM SHALL abort to SPARE next cycle with no mac_clr pulse.
REQ-011 In DRAIN_S, fault_inject and stress changes SHALL NOT alter the sequence.
REQ-012 mac_clr SHALL pulse for one cycle on the first drain cycle of the destination node: bit1 in DRAIN_S, bit0 in DRAIN_P.
REQ-013 in_ready SHALL be 1 in PRIM and SPARE and 0 in both drain states.
REQ-014 route_sel SHALL be 1 in DRAIN_S and SPARE and 0 in PRIM and DRAIN_P.
REQ-015 An accepted transaction SHALL appear registered on node_data_a/b with exactly one of n0_valid/n1_valid high one cycle after acceptance (latency 1), per route_sel in the accept cycle.
REQ-016 Without an accept, both strobes SHALL be 0 and node_data_a/b SHALL be 0 in the next cycle.
REQ-017 decay_pulse SHALL be high for one cycle every DECAY_DIV cycles, first pulse DECAY_DIV cycles after reset release, free-running independent of the FSM.
REQ-018 Threshold compares SHALL be unsigned 8-bit; n0_stress == HI_THRESH SHALL NOT trigger failover.

Reset
REQ-019 While rst_n is low, state SHALL be PRIM; in_ready SHALL be 1; n0_valid, n1_valid, node_data_a, node_data_b, mac_clr, decay_pulse, route_sel and counters SHALL be 0.
REQ-020 Reset asserted mid-drain SHALL discard the drain; any pending output strobe SHALL be dropped.

Configuration
REQ-021 With macro STRESS_ROUTER_STATS_EN defined, the block SHALL add output failover_cnt (16 bits, reset 0), incremented on each PRIM->DRAIN_S entry and saturating at 65535.
REQ-022 Without STRESS_ROUTER_STATS_EN, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-023 Stream in_valid=1, a=5, b=3, n0_stress=50 -> n0_valid=1 with node_data_a=5 and node_data_b=3 one cycle after each accept; n1_valid stays 0.
REQ-024 Set n0_stress=201 in PRIM -> in_ready=0 for 2 cycles, mac_clr=2'b10 on the first of them, then route_sel=1 and traffic on n1_valid; n0_stress=200 -> no switch.
REQ-025 In SPARE, step n0_stress 150 then 99 -> no transition at 150; DRAIN_P at 99, mac_clr=2'b01, return to PRIM after 2 cycles.
REQ-026 During DRAIN_P, pulse fault_inject -> FSM back in SPARE next cycle, mac_clr stays 0, failover_cnt unchanged.
REQ-027 Assert rst_n=0 mid-DRAIN_S -> all outputs 0 except in_ready=1, state PRIM; decay_pulse resumes 16 cycles after release.
REQ-028 With STRESS_ROUTER_STATS_EN, run 3 fault_inject failovers -> failover_cnt=3.
